// File: rtl/egress_pkg.sv
// rtl/egress_pkg.sv - shared types and helper functions for the egress arbiter slice
// Contents: FSM state type, clog2, eff_width, and the round-robin first-set-bit helper.
package egress_pkg;

   // Upper bound on sources the round-robin helper can scan (AXIS_ID_WIDTH <= 8).
   localparam int RR_MAX = 256;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int eff_width(input int w);
      return (w < 1) ? 1 : w;
   endfunction

   // First set bit of mask[n-1:0], scanning upward from ptr with wrap-around.
   // Scanning the offsets from the far end back toward ptr leaves the nearest hit.
   function automatic int rr_first(input logic [RR_MAX-1:0] mask, input int ptr, input int n);
      int idx;
      int res;
      res = 0;
      for (int k = n - 1; k >= 0; k--) begin
         idx = (ptr + k) % n;
         if (mask[idx[7:0]]) res = idx;
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational masked round-robin priority encoder
// Ports: mask  - request vector, one bit per source
//        ptr   - index the scan starts from (highest priority)
//        index - selected source (0 when nothing is requested)
//        found - high when any mask bit is set
module rr_select
   import egress_pkg::*;
#(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] index,
   output logic         found
);

   logic [RR_MAX-1:0] mask_ext;
   int                sel;

   always_comb begin
      mask_ext = RR_MAX'(mask);
      sel      = rr_first(mask_ext, int'(ptr), N);
      index    = W'(sel);
      found    = |mask;
   end

endmodule

// File: rtl/egress_arbiter.sv
// rtl/egress_arbiter.sv - packet-granular round-robin arbiter feeding the egress filter chain
// Ports: aclk/areset            - clock, synchronous active-high reset
//        axis_in_*              - packed per-source AXI-Stream inputs, source i in slice i
//        axis_out_*             - muxed stream; tid = granted source, tdest = its tdest
//        port_enable            - sources eligible for a new grant (sampled in IDLE only)
//        grant_active/grant_id  - lock status and current/most recent grant
module egress_arbiter
   import egress_pkg::*;
#(
   parameter int AXIS_BUS_WIDTH  = 64,
   parameter int AXIS_ID_WIDTH   = 4,
   parameter int AXIS_DEST_WIDTH = 4,
   localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8,
   localparam int NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH,
   localparam int EFF_ID_WIDTH   = eff_width(AXIS_ID_WIDTH),
   localparam int EFF_DEST_WIDTH = eff_width(AXIS_DEST_WIDTH)
) (
   input  logic                                  aclk,
   input  logic                                  areset,
   input  logic [NUM_AXIS_ID*AXIS_BUS_WIDTH-1:0] axis_in_tdata,
   input  logic [NUM_AXIS_ID*EFF_DEST_WIDTH-1:0] axis_in_tdest,
   input  logic [NUM_AXIS_ID*NUM_BUS_BYTES-1:0]  axis_in_tkeep,
   input  logic [NUM_AXIS_ID-1:0]                axis_in_tlast,
   input  logic [NUM_AXIS_ID-1:0]                axis_in_tvalid,
   output logic [NUM_AXIS_ID-1:0]                axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]             axis_out_tdata,
   output logic [EFF_ID_WIDTH-1:0]               axis_out_tid,
   output logic [EFF_DEST_WIDTH-1:0]             axis_out_tdest,
   output logic [NUM_BUS_BYTES-1:0]              axis_out_tkeep,
   output logic                                  axis_out_tlast,
   output logic                                  axis_out_tvalid,
   input  logic                                  axis_out_tready,
   input  logic [NUM_AXIS_ID-1:0]                port_enable,
   output logic                                  grant_active,
   output logic [EFF_ID_WIDTH-1:0]               grant_id
);

   arb_state_t                state, state_nxt;
   logic [EFF_ID_WIDTH-1:0]   grant_nxt;
   logic [EFF_ID_WIDTH-1:0]   rr_ptr, rr_nxt;
   logic [NUM_AXIS_ID-1:0]    eligible;
   logic [EFF_ID_WIDTH-1:0]   rr_index;
   logic                      rr_found;

   logic [AXIS_BUS_WIDTH-1:0] sel_tdata;
   logic [EFF_DEST_WIDTH-1:0] sel_tdest;
   logic [NUM_BUS_BYTES-1:0]  sel_tkeep;
   logic                      sel_tlast;
   logic                      sel_tvalid;

   assign eligible = axis_in_tvalid & port_enable;

   rr_select #(
      .N (NUM_AXIS_ID),
      .W (EFF_ID_WIDTH)
   ) u_rr_select (
      .mask  (eligible),
      .ptr   (rr_ptr),
      .index (rr_index),
      .found (rr_found)
   );

   // Source mux follows grant_id in every state, so the data outputs hold the
   // last granted source's lane while idle instead of going X.
   always_comb begin
      sel_tdata  = '0;
      sel_tdest  = '0;
      sel_tkeep  = '0;
      sel_tlast  = 1'b0;
      sel_tvalid = 1'b0;
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
         if (grant_id == EFF_ID_WIDTH'(i)) begin
            sel_tdata  = axis_in_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
            sel_tdest  = axis_in_tdest[i*EFF_DEST_WIDTH +: EFF_DEST_WIDTH];
            sel_tkeep  = axis_in_tkeep[i*NUM_BUS_BYTES +: NUM_BUS_BYTES];
            sel_tlast  = axis_in_tlast[i];
            sel_tvalid = axis_in_tvalid[i];
         end
      end
   end

   assign axis_out_tdata = sel_tdata;
   assign axis_out_tkeep = sel_tkeep;
   assign axis_out_tlast = sel_tlast;
   assign axis_out_tid   = grant_id;
   assign axis_out_tdest = (AXIS_DEST_WIDTH == 0) ? '0 : sel_tdest;
   assign grant_active   = (state == ST_BUSY);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= ST_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         rr_ptr   <= rr_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant_id;
      rr_nxt          = rr_ptr;
      axis_in_tready  = '0;
      axis_out_tvalid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rr_found) begin
               grant_nxt = rr_index;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            axis_out_tvalid = sel_tvalid;
            for (int i = 0; i < NUM_AXIS_ID; i++) begin
               axis_in_tready[i] = (grant_id == EFF_ID_WIDTH'(i)) && axis_out_tready;
            end
            // Lock releases only on the accepted tlast beat; port_enable is ignored here.
            if (sel_tvalid && axis_out_tready && sel_tlast) begin
               state_nxt = ST_IDLE;
               rr_nxt    = (grant_id == EFF_ID_WIDTH'(NUM_AXIS_ID - 1)) ?
                           '0 : grant_id + EFF_ID_WIDTH'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Reset is synchronous, so the state may still read BUSY in the reset cycle.
      if (areset) begin
         axis_in_tready  = '0;
         axis_out_tvalid = 1'b0;
      end
   end

endmodule

// File: tb/tb_egress_arbiter.sv
// tb/tb_egress_arbiter.sv - directed self-checking bench for egress_arbiter with four sources
module tb_egress_arbiter;

   logic         aclk = 1'b0;
   logic         areset;
   logic [255:0] in_tdata;
   logic [15:0]  in_tdest;
   logic [31:0]  in_tkeep;
   logic [3:0]   in_tlast;
   logic [3:0]   in_tvalid;
   logic [3:0]   in_tready;
   logic [63:0]  out_tdata;
   logic [1:0]   out_tid;
   logic [3:0]   out_tdest;
   logic [7:0]   out_tkeep;
   logic         out_tlast;
   logic         out_tvalid;
   logic         out_tready;
   logic [3:0]   port_enable;
   logic         grant_active;
   logic [1:0]   grant_id;

   logic [63:0]  s_data [4];
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 aclk = ~aclk;

   // Each source carries a fixed tdest (i+5) and tkeep (A0+i) so the mux lane is visible.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         in_tdata[i*64 +: 64] = s_data[i];
         in_tdest[i*4 +: 4]   = 4'(i + 5);
         in_tkeep[i*8 +: 8]   = 8'(8'hA0 + i);
      end
   end

   egress_arbiter #(
      .AXIS_BUS_WIDTH  (64),
      .AXIS_ID_WIDTH   (2),
      .AXIS_DEST_WIDTH (4)
   ) dut (
      .aclk            (aclk),
      .areset          (areset),
      .axis_in_tdata   (in_tdata),
      .axis_in_tdest   (in_tdest),
      .axis_in_tkeep   (in_tkeep),
      .axis_in_tlast   (in_tlast),
      .axis_in_tvalid  (in_tvalid),
      .axis_in_tready  (in_tready),
      .axis_out_tdata  (out_tdata),
      .axis_out_tid    (out_tid),
      .axis_out_tdest  (out_tdest),
      .axis_out_tkeep  (out_tkeep),
      .axis_out_tlast  (out_tlast),
      .axis_out_tvalid (out_tvalid),
      .axis_out_tready (out_tready),
      .port_enable     (port_enable),
      .grant_active    (grant_active),
      .grant_id        (grant_id)
   );

   function automatic logic [63:0] bd(input int src, input int beat);
      return 64'(src * 16 + beat);
   endfunction

   task automatic cyc;
      @(posedge aclk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".tvalid"}, 64'(out_tvalid), 64'd0);
      chk({tag, ".tready"}, 64'(in_tready), 64'd0);
      chk({tag, ".active"}, 64'(grant_active), 64'd0);
   endtask

   task automatic chk_beat(input string tag, input int id, input logic [63:0] data, input logic last);
      logic [3:0] exp_rdy;
      exp_rdy = out_tready ? 4'(1 << id) : 4'b0000;
      chk({tag, ".tvalid"}, 64'(out_tvalid), 64'd1);
      chk({tag, ".tdata"}, out_tdata, data);
      chk({tag, ".tid"}, 64'(out_tid), 64'(id));
      chk({tag, ".tdest"}, 64'(out_tdest), 64'(id + 5));
      chk({tag, ".tkeep"}, 64'(out_tkeep), 64'(8'hA0 + id));
      chk({tag, ".tlast"}, 64'(out_tlast), 64'(last));
      chk({tag, ".tready"}, 64'(in_tready), 64'(exp_rdy));
      chk({tag, ".active"}, 64'(grant_active), 64'd1);
      chk({tag, ".grant_id"}, 64'(grant_id), 64'(id));
   endtask

   initial begin
      int b;
      logic tr;
      areset      = 1'b1;
      in_tvalid   = 4'hF;
      in_tlast    = 4'h0;
      out_tready  = 1'b1;
      port_enable = 4'hF;
      for (int i = 0; i < 4; i++) s_data[i] = bd(i, 0);

      // Reset: sources valid, but nothing may be granted or readied.
      cyc;
      cyc;
      settle;
      chk_idle("rst");
      chk("rst.grant_id", 64'(grant_id), 64'd0);

      // Test 1: sources 0 and 2 each send a 3-beat packet.
      areset    = 1'b0;
      in_tvalid = 4'b0101;
      s_data[0] = bd(0, 0);
      s_data[2] = bd(2, 0);
      settle;
      chk_idle("t1_idle");
      for (int k = 0; k < 3; k++) begin
         cyc;
         s_data[0]   = bd(0, k);
         in_tlast[0] = (k == 2);
         settle;
         chk_beat("t1_s0", 0, bd(0, k), k == 2);
      end
      cyc;
      in_tvalid[0] = 1'b0;
      in_tlast[0]  = 1'b0;
      settle;
      chk_idle("t1_gap");
      for (int k = 0; k < 3; k++) begin
         cyc;
         s_data[2]   = bd(2, k);
         in_tlast[2] = (k == 2);
         settle;
         chk_beat("t1_s2", 2, bd(2, k), k == 2);
      end
      cyc;
      in_tvalid[2] = 1'b0;
      in_tlast[2]  = 1'b0;
      settle;
      chk_idle("t1_end");

      // Test 2: after a reset, all four stream 1-beat packets; grants rotate 0..3.
      areset = 1'b1;
      cyc;
      areset    = 1'b0;
      in_tvalid = 4'hF;
      in_tlast  = 4'hF;
      for (int i = 0; i < 4; i++) s_data[i] = bd(i, 0);
      settle;
      chk_idle("t2_idle");
      for (int k = 0; k < 6; k++) begin
         cyc;
         settle;
         chk_beat("t2_rr", k % 4, bd(k % 4, 0), 1'b1);
         cyc;
         if (k == 5) begin
            in_tvalid = 4'h0;
            in_tlast  = 4'h0;
         end
         settle;
         chk_idle("t2_gap");
      end

      // Test 3: source 1 sends 4 beats while downstream ready toggles 1,0,1,0...
      in_tvalid[1] = 1'b1;
      s_data[1]    = bd(1, 0);
      b = 0;
      cyc;
      for (int j = 0; j < 7; j++) begin
         tr          = (j % 2 == 0);
         out_tready  = tr;
         s_data[1]   = bd(1, b);
         in_tlast[1] = (b == 3);
         settle;
         chk_beat("t3_s1", 1, bd(1, b), b == 3);
         if (tr) b++;
         cyc;
      end
      in_tvalid[1] = 1'b0;
      in_tlast[1]  = 1'b0;
      out_tready   = 1'b1;
      settle;
      chk_idle("t3_end");

      // Test 4: source 1 valid but disabled; source 3 keeps its lock after disable.
      port_enable = 4'b1101;
      in_tvalid   = 4'b1010;
      s_data[1]   = bd(1, 0);
      s_data[3]   = bd(3, 0);
      settle;
      chk_idle("t4_idle");
      for (int k = 0; k < 5; k++) begin
         cyc;
         s_data[3]   = bd(3, k);
         in_tlast[3] = (k == 4);
         if (k == 1) port_enable = 4'b0101;
         settle;
         chk_beat("t4_s3", 3, bd(3, k), k == 4);
      end
      cyc;
      in_tvalid[3] = 1'b0;
      in_tlast[3]  = 1'b0;
      settle;
      chk_idle("t4_stall0");
      cyc;
      settle;
      chk_idle("t4_stall1");
      in_tvalid[1] = 1'b0;
      port_enable  = 4'hF;

      // Test 5: reset on beat 2 of a source-2 packet, then everyone valid.
      in_tvalid[2] = 1'b1;
      s_data[2]    = bd(2, 0);
      for (int k = 0; k < 2; k++) begin
         cyc;
         s_data[2] = bd(2, k);
         settle;
         chk_beat("t5_s2", 2, bd(2, k), 1'b0);
      end
      cyc;
      areset    = 1'b1;
      in_tvalid = 4'hF;
      s_data[0] = bd(0, 0);
      s_data[1] = bd(1, 0);
      s_data[2] = bd(2, 2);
      s_data[3] = bd(3, 0);
      settle;
      chk("t5_rst.tvalid", 64'(out_tvalid), 64'd0);
      chk("t5_rst.tready", 64'(in_tready), 64'd0);
      cyc;
      areset = 1'b0;
      settle;
      chk_idle("t5_post");
      chk("t5_post.grant_id", 64'(grant_id), 64'd0);
      cyc;
      in_tlast[0] = 1'b1;
      settle;
      chk_beat("t5_first", 0, bd(0, 0), 1'b1);
      cyc;
      in_tvalid = 4'h0;
      in_tlast  = 4'h0;
      settle;
      chk_idle("t5_end");

      // Test 6: source 3 drops tvalid for 2 cycles mid-packet while source 0 waits.
      in_tvalid[3] = 1'b1;
      s_data[3]    = bd(3, 0);
      cyc;
      in_tvalid[0] = 1'b1;
      in_tlast[0]  = 1'b1;
      s_data[0]    = bd(0, 0);
      settle;
      chk_beat("t6_b0", 3, bd(3, 0), 1'b0);
      for (int d = 0; d < 2; d++) begin
         cyc;
         in_tvalid[3] = 1'b0;
         s_data[3]    = bd(3, 1);
         settle;
         chk("t6_drop.tvalid", 64'(out_tvalid), 64'd0);
         chk("t6_drop.active", 64'(grant_active), 64'd1);
         chk("t6_drop.tid", 64'(out_tid), 64'd3);
         chk("t6_drop.tready", 64'(in_tready), 64'h8);
      end
      cyc;
      in_tvalid[3] = 1'b1;
      settle;
      chk_beat("t6_b1", 3, bd(3, 1), 1'b0);
      cyc;
      s_data[3]   = bd(3, 2);
      in_tlast[3] = 1'b1;
      settle;
      chk_beat("t6_b2", 3, bd(3, 2), 1'b1);
      cyc;
      in_tvalid[3] = 1'b0;
      in_tlast[3]  = 1'b0;
      settle;
      chk_idle("t6_gap");
      cyc;
      settle;
      chk_beat("t6_s0", 0, bd(0, 0), 1'b1);
      cyc;
      in_tvalid = 4'h0;
      in_tlast  = 4'h0;
      settle;
      chk_idle("t6_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
